// File: rtl/rx_power_framer_if.sv
// Frame word stream from rx_power_framer toward the RX host path (valid/ready).
interface rx_power_framer_if;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;

    modport master (output o_tdata, output o_tlast, output o_tvalid, input o_tready);
    modport slave  (input o_tdata, input o_tlast, input o_tvalid, output o_tready);
endinterface

// File: rtl/rx_power_framer.sv
// Packs DDC power samples into timestamped frames; whole-frame admission with in-band drop flag.
// Optional macro RX_FRAMER_SID_EN adds a BASE+1 stream-id register and a leading SID word.
module rx_power_framer #(
    parameter int unsigned BASE    = 0,
    parameter int unsigned FIFO_AW = 9,
    parameter int unsigned HDR_AW  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_stb,
    input  logic [7:0]               set_addr,
    input  logic [31:0]              set_data,
    input  logic                     run,
    input  logic [31:0]              sample,
    input  logic                     strobe,
    input  logic [63:0]              vita_time,
    rx_power_framer_if.master        m_if,
    output logic [15:0]              overflow_count
);

    localparam logic [31:0] DDEPTH = 32'(1) << FIFO_AW;

    typedef struct packed {
        logic        ovf;
        logic [11:0] seq;
        logic [15:0] len;
        logic [63:0] tstamp;
`ifdef RX_FRAMER_SID_EN
        logic [7:0]  sid;
`endif
    } hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef RX_FRAMER_SID_EN
        ST_SID,
`endif
        ST_HDR,
        ST_TSH,
        ST_TSL,
        ST_PAY
    } state_t;

    // settings
    logic [15:0] flen_q;
    logic [15:0] alen_q, alen_d;
`ifdef RX_FRAMER_SID_EN
    logic [7:0]  sid_q;
    logic [7:0]  asid_q, asid_d;
`endif

    // capture side
    logic [15:0] cnt_q, cnt_d;
    logic        drop_q, drop_d;
    logic [15:0] dleft_q, dleft_d;
    logic [63:0] time_q, time_d;
    logic [11:0] seq_q, seq_d;
    logic        ovfp_q, ovfp_d;
    logic [15:0] ovfc_q, ovfc_d;

    // FIFOs
    logic [31:0]       d_mem [DDEPTH];
    hdr_t              h_mem [1 << HDR_AW];
    logic [FIFO_AW:0]  d_wr_q, d_rd_q;
    logic [HDR_AW:0]   h_wr_q, h_rd_q;
    logic [FIFO_AW:0]  d_occ_post;
    logic [HDR_AW:0]   h_occ, h_occ_post;
    logic [31:0]       d_free;
    logic              h_empty;
    hdr_t              h_head, hdr_in;

    // output side
    state_t      st_q, st_d;
    logic [15:0] pay_q, pay_d;
    logic        d_pop, h_pop;
    logic        tvalid, tlast;
    logic [31:0] tdata;

    logic        start, admit, cap_wr, close;
    logic [15:0] len_cur, cnt_inc;

    logic unused_set_bits;
`ifdef RX_FRAMER_SID_EN
    assign unused_set_bits = ^set_data[31:16];
`else
    assign unused_set_bits = ^set_data[31:16];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flen_q <= 16'd1;
`ifdef RX_FRAMER_SID_EN
            sid_q  <= '0;
`endif
        end else if (set_stb) begin
            if (set_addr == 8'(BASE))
                flen_q <= (set_data[15:0] == '0) ? 16'd1 : set_data[15:0];
`ifdef RX_FRAMER_SID_EN
            if (set_addr == 8'(BASE + 1))
                sid_q <= set_data[7:0];
`endif
        end
    end

    always_comb begin
        h_occ      = h_wr_q - h_rd_q;
        h_empty    = (h_occ == '0);
        h_occ_post = h_occ - {{HDR_AW{1'b0}}, h_pop};
        // Space is judged against occupancy after this cycle's pop.
        d_occ_post = d_wr_q - d_rd_q - {{FIFO_AW{1'b0}}, d_pop};
        d_free     = DDEPTH - 32'(d_occ_post);

        start   = run && strobe && (cnt_q == '0) && !drop_q;
        admit   = start && !h_occ_post[HDR_AW] && (d_free >= 32'(flen_q));
        cap_wr  = admit || (run && strobe && (cnt_q != '0));
        len_cur = (cnt_q == '0) ? flen_q : alen_q;
        cnt_inc = cnt_q + 16'd1;
        close   = (cap_wr && (cnt_inc == len_cur)) || (!run && (cnt_q != '0));

        hdr_in        = '0;
        hdr_in.ovf    = ovfp_q;
        hdr_in.seq    = seq_q;
        hdr_in.len    = cap_wr ? cnt_inc : cnt_q;
        hdr_in.tstamp = (cnt_q == '0) ? vita_time : time_q;
`ifdef RX_FRAMER_SID_EN
        hdr_in.sid    = (cnt_q == '0) ? sid_q : asid_q;
`endif

        cnt_d  = cnt_q;
        drop_d = drop_q;
        dleft_d = dleft_q;
        time_d = time_q;
        seq_d  = seq_q;
        ovfp_d = ovfp_q;
        ovfc_d = ovfc_q;
        alen_d = alen_q;
`ifdef RX_FRAMER_SID_EN
        asid_d = asid_q;
`endif

        if (start) begin
            alen_d = flen_q;
`ifdef RX_FRAMER_SID_EN
            asid_d = sid_q;
`endif
        end
        if (admit) time_d = vita_time;
        if (cap_wr) cnt_d = cnt_inc;
        if (close) begin
            cnt_d  = '0;
            ovfp_d = 1'b0;
            seq_d  = seq_q + 12'd1;
        end

        if (start && !admit) begin
            ovfc_d = (ovfc_q == '1) ? ovfc_q : ovfc_q + 16'd1;
            ovfp_d = 1'b1;
            if (flen_q != 16'd1) begin
                drop_d  = 1'b1;
                dleft_d = flen_q - 16'd1;
            end
        end else if (drop_q) begin
            if (!run) begin
                drop_d = 1'b0;
            end else if (strobe) begin
                dleft_d = dleft_q - 16'd1;
                if (dleft_q == 16'd1) drop_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            dleft_q <= '0;
            time_q  <= '0;
            seq_q   <= '0;
            ovfp_q  <= 1'b0;
            ovfc_q  <= '0;
            alen_q  <= 16'd1;
`ifdef RX_FRAMER_SID_EN
            asid_q  <= '0;
`endif
            d_wr_q  <= '0;
            d_rd_q  <= '0;
            h_wr_q  <= '0;
            h_rd_q  <= '0;
            st_q    <= ST_IDLE;
            pay_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            dleft_q <= dleft_d;
            time_q  <= time_d;
            seq_q   <= seq_d;
            ovfp_q  <= ovfp_d;
            ovfc_q  <= ovfc_d;
            alen_q  <= alen_d;
`ifdef RX_FRAMER_SID_EN
            asid_q  <= asid_d;
`endif
            if (cap_wr) d_wr_q <= d_wr_q + 1'b1;
            if (d_pop)  d_rd_q <= d_rd_q + 1'b1;
            if (close)  h_wr_q <= h_wr_q + 1'b1;
            if (h_pop)  h_rd_q <= h_rd_q + 1'b1;
            st_q    <= st_d;
            pay_q   <= pay_d;
        end
    end

    // Header is pushed in the same cycle as the last payload write, so it never overtakes its data.
    always_ff @(posedge clk) begin
        if (cap_wr) d_mem[d_wr_q[FIFO_AW-1:0]] <= sample;
        if (close)  h_mem[h_wr_q[HDR_AW-1:0]] <= hdr_in;
    end

    assign h_head = h_mem[h_rd_q[HDR_AW-1:0]];

    always_comb begin
        st_d   = st_q;
        pay_d  = pay_q;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
        d_pop  = 1'b0;
        h_pop  = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
`ifdef RX_FRAMER_SID_EN
                if (!h_empty) st_d = ST_SID;
`else
                if (!h_empty) st_d = ST_HDR;
`endif
            end
`ifdef RX_FRAMER_SID_EN
            ST_SID: begin
                tvalid = 1'b1;
                tdata  = {24'h0, h_head.sid};
                if (m_if.o_tready) st_d = ST_HDR;
            end
`endif
            ST_HDR: begin
                tvalid = 1'b1;
                tdata  = {h_head.ovf, 3'b000, h_head.seq, h_head.len};
                if (m_if.o_tready) st_d = ST_TSH;
            end
            ST_TSH: begin
                tvalid = 1'b1;
                tdata  = h_head.tstamp[63:32];
                if (m_if.o_tready) st_d = ST_TSL;
            end
            ST_TSL: begin
                tvalid = 1'b1;
                tdata  = h_head.tstamp[31:0];
                if (m_if.o_tready) begin
                    st_d  = ST_PAY;
                    pay_d = '0;
                end
            end
            ST_PAY: begin
                tvalid = 1'b1;
                tdata  = d_mem[d_rd_q[FIFO_AW-1:0]];
                tlast  = (pay_q == h_head.len - 16'd1);
                if (m_if.o_tready) begin
                    d_pop = 1'b1;
                    if (tlast) begin
                        h_pop = 1'b1;
                        st_d  = ST_IDLE;
                    end else begin
                        pay_d = pay_q + 16'd1;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    assign m_if.o_tdata    = tdata;
    assign m_if.o_tlast    = tlast;
    assign m_if.o_tvalid   = tvalid;
    assign overflow_count  = ovfc_q;

endmodule

// File: tb/tb_rx_power_framer.sv
// Scoreboard bench for rx_power_framer: expected words queued at drive time, popped on accept.
`timescale 1ns/1ps
module tb_rx_power_framer;

    localparam int unsigned FAW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic        run = 1'b0;
    logic [31:0] sample = '0;
    logic        strobe = 1'b0;
    logic [63:0] vita_time = '0;
    logic [15:0] overflow_count;
    logic        rdy = 1'b1;
    logic        tog_en = 1'b0;

    rx_power_framer_if bus();
    assign bus.o_tready = rdy;

    rx_power_framer #(.BASE(0), .FIFO_AW(FAW), .HDR_AW(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .set_stb        (set_stb),
        .set_addr       (set_addr),
        .set_data       (set_data),
        .run            (run),
        .sample         (sample),
        .strobe         (strobe),
        .vita_time      (vita_time),
        .m_if           (bus),
        .overflow_count (overflow_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    int n_pop = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare accepted words, and hold-stability while stalled.
    logic        held = 1'b0;
    logic [32:0] held_w = '0;
    always @(negedge clk) begin
        logic [32:0] w;
        if (!rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", 64'(bus.o_tvalid), 64'd1);
                check("stall_data", 64'({bus.o_tlast, bus.o_tdata}), 64'(held_w));
            end
            if (bus.o_tvalid && bus.o_tready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    check("extra_word_queue", 64'(exp_q.size()), 64'd1);
                end else begin
                    w = exp_q.pop_front();
                    check("word", 64'({bus.o_tlast, bus.o_tdata}), 64'(w));
                end
            end
            held   = bus.o_tvalid && !bus.o_tready;
            held_w = {bus.o_tlast, bus.o_tdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        vita_time = vita_time + 64'd1;
        if (tog_en) rdy = ~rdy;
    endtask

    task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        tick();
        set_stb  = 1'b0;
    endtask

    task automatic send(input logic [31:0] s0, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            sample = s0 + 32'(i);
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
        end
    endtask

    task automatic push_frame(input logic ovf, input logic [11:0] seq, input logic [15:0] len,
                              input logic [63:0] t, input logic [31:0] s0);
`ifdef RX_FRAMER_SID_EN
        exp_q.push_back(33'h0);
`endif
        exp_q.push_back({1'b0, ovf, 3'b000, seq, len});
        exp_q.push_back({1'b0, t[63:32]});
        exp_q.push_back({1'b0, t[31:0]});
        for (int unsigned i = 0; i < 32'(len); i++)
            exp_q.push_back({(i == 32'(len) - 1), s0 + 32'(i)});
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] t;
        int base;
        int unsigned k;

        repeat (3) tick();
        check("rst_tvalid", 64'(bus.o_tvalid), 64'd0);
        check("rst_tdata", 64'(bus.o_tdata), 64'd0);
        check("rst_tlast", 64'(bus.o_tlast), 64'd0);
        check("rst_ovf", 64'(overflow_count), 64'd0);
        rst = 1'b1;
        tick();

        // Two back-to-back frames of 4, sink always ready
        set_reg(8'h00, 32'd4);
        run = 1'b1;
        vita_time = 64'h0000_0001_0000_0010;
        t = vita_time;
        push_frame(1'b0, 12'd0, 16'd4, t, 32'hA000_0000);
        push_frame(1'b0, 12'd1, 16'd4, t + 64'd4, 32'hA000_0004);
        send(32'hA000_0000, 8);
        drain(100);
        check("ovf_none", 64'(overflow_count), 64'd0);

        // Unmapped write must not disturb frame_len; sink toggles every cycle
        set_reg(8'h07, 32'd2);
        tog_en = 1'b1;
        t = vita_time;
        push_frame(1'b0, 12'd2, 16'd4, t, 32'hB000_0000);
        push_frame(1'b0, 12'd3, 16'd4, t + 64'd4, 32'hB000_0004);
        send(32'hB000_0000, 8);
        drain(200);
        tog_en = 1'b0;
        rdy = 1'b1;

        // Full-depth frame admitted into empty FIFO; next one dropped while stalled
        rdy = 1'b0;
        set_reg(8'h00, 32'd16);
        t = vita_time;
        push_frame(1'b0, 12'd4, 16'd16, t, 32'hC000_0000);
        send(32'hC000_0000, 32);
        check("ovf_data_full", 64'(overflow_count), 64'd1);
        rdy = 1'b1;
        drain(200);
        t = vita_time;
        push_frame(1'b1, 12'd5, 16'd16, t, 32'hC100_0000);
        send(32'hC100_0000, 16);
        drain(200);

        // frame_len 0 acts as 1; fifth frame dropped on a full header FIFO
        rdy = 1'b0;
        set_reg(8'h00, 32'd0);
        t = vita_time;
        for (int unsigned i = 0; i < 4; i++)
            push_frame(1'b0, 12'(6 + i), 16'd1, t + 64'(i), 32'hD000_0000 + 32'(i));
        send(32'hD000_0000, 5);
        check("ovf_hdr_full", 64'(overflow_count), 64'd2);
        rdy = 1'b1;
        drain(200);
        t = vita_time;
        push_frame(1'b1, 12'd10, 16'd1, t, 32'hE000_0000);
        send(32'hE000_0000, 1);
        drain(100);

        // run falls after 3 of 10 strobes -> truncated frame
        set_reg(8'h00, 32'd10);
        t = vita_time;
        push_frame(1'b0, 12'd11, 16'd3, t, 32'hF000_0000);
        send(32'hF000_0000, 3);
        run = 1'b0;
        sample = 32'h1234_5678;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        run = 1'b1;
        t = vita_time;
        push_frame(1'b0, 12'd12, 16'd10, t, 32'hF000_0010);
        send(32'hF000_0010, 10);
        drain(200);

        // frame_len rewritten mid-frame applies only to the following frame
        set_reg(8'h00, 32'd5);
        t = vita_time;
        push_frame(1'b0, 12'd13, 16'd5, t, 32'h9000_0000);
        send(32'h9000_0000, 2);
        set_reg(8'h00, 32'd2);
        send(32'h9000_0002, 3);
        t = vita_time;
        push_frame(1'b0, 12'd14, 16'd2, t, 32'h9000_0005);
        send(32'h9000_0005, 2);
        drain(200);

        // Reset in the middle of payload
        rdy = 1'b0;
        set_reg(8'h00, 32'd8);
        t = vita_time;
        push_frame(1'b0, 12'd15, 16'd8, t, 32'h7000_0000);
        send(32'h7000_0000, 8);
        run = 1'b0;
        base = n_pop;
        rdy = 1'b1;
        k = 0;
        while ((n_pop - base) < 4 && k < 100) begin
            tick();
            k++;
        end
        check("mid_payload_reached", 64'(n_pop - base), 64'd4);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_tvalid", 64'(bus.o_tvalid), 64'd0);
        check("rst_mid_tdata", 64'(bus.o_tdata), 64'd0);
        check("rst_mid_ovf", 64'(overflow_count), 64'd0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();
        set_reg(8'h00, 32'd4);
        run = 1'b1;
        t = vita_time;
        push_frame(1'b0, 12'd0, 16'd4, t, 32'h6000_0000);
        send(32'h6000_0000, 4);
        drain(100);
        check("ovf_after_rst", 64'(overflow_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_power_framer.md
Name: rx_power_framer

Overview:
- Downstream of the DDC chain: consumes the 32-bit integrated power samples (sample/strobe) and packs them into timestamped frames on a 32-bit valid/ready stream toward the RX host path.
- Admission is per frame: a frame is buffered whole or dropped whole, never split, and drops are reported in-band.
- Seq/len of each frame sit in a small header FIFO; payload sits in a data FIFO.

Parameters:
BASE, 0, settings-bus base address
FIFO_AW, 9, data FIFO address width (depth 2^FIFO_AW words)
HDR_AW, 2, header FIFO address width (depth 2^HDR_AW frames)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (asserted at 0)
set_stb  in  1  settings write strobe
set_addr  in  8  settings address
set_data  in  32  settings data
run  in  1  capture enable from RX control
sample  in  32  power sample from DDC chain
strobe  in  1  sample valid, single-cycle
vita_time  in  64  current time, sampled with first sample of a frame
o_tdata  out  32  frame word
o_tlast  out  1  last word of frame
o_tvalid  out  1  word valid
o_tready  in  1  downstream accept
overflow_count  out  16  saturating count of dropped frames

Behaviour:
- Reset (rst=0): all outputs 0, FIFOs empty, seq=0, frame_len reg=1, ovf_pending=0, capture count=0, output FSM IDLE.
- Register BASE+0: frame_len[15:0]; value 0 treated as 1. Latched into active_len only at frame start; mid-frame writes do not alter the current frame.
- Capture side, count=0 and strobe&run (frame start):
  - admit iff header FIFO not full and data-FIFO free space >= active_len; admitted: latch vita_time, write sample, count=1.
  - not admitted: drop mode for active_len strobes (no writes); overflow_count+1 (saturates at 16'hFFFF); ovf_pending=1.
- Admitted frame: each strobe&run writes sample, count+1.
- Close when count reaches active_len on a write, or on run falling while count>0 (truncated frame).
- Close pushes {ovf_pending, seq, len=count, time} into header FIFO; ovf_pending cleared, seq+1 (12-bit, 4095 wraps to 0).
- run low also aborts drop mode; strobe with run=0 is ignored.
- Header push always follows its last payload write, so a popped header's payload is fully resident.
- Output FSM: IDLE -> HDR -> TSH -> TSL -> PAY -> IDLE.
  - IDLE: leave when header FIFO non-empty.
  - word0 = {ovf, 3'b000, seq[11:0], len[15:0]}; word1 = time[63:32]; word2 = time[31:0]; then len payload words, o_tlast on final payload word only.
  - Each state advances only on o_tvalid&o_tready. Header popped on last-word acceptance.
  - o_tdata/o_tlast held stable while o_tvalid&~o_tready. Min latency: header push to o_tvalid=1 is 1 cycle.
- Simultaneous FIFO read and write in one cycle are both honoured; free space uses post-cycle occupancy.
- Full-depth frame (len = 2^FIFO_AW) is admitted only into an empty data FIFO.
- Settings write to unmapped address: ignored.

Optional Feature:
- Macro RX_FRAMER_SID_EN.
- Defined: register BASE+1 holds sid[7:0], latched at frame start with active_len. Each frame gains a leading word {24'h0, sid} before word0, in FSM state SID between IDLE and HDR.
- Not defined: no BASE+1 register (writes ignored); frames are exactly 3 header words + payload.

Test Plan:
- frame_len=4, run=1, 8 strobes, time 0x0000_0001_0000_0010 at first strobe, o_tready=1 -> two frames: 0x0000_0004 / 0x00000001 / 0x00000010 / 4 payload (tlast on 4th), then 0x0001_0004.
- frame_len=4, o_tready toggled every other cycle -> identical word sequence, o_tdata stable while stalled.
- FIFO_AW=3, frame_len=8, o_tready=0, 16 strobes -> frame 1 admitted, frame 2 dropped; overflow_count=1; after release next admitted frame's word0 bit31=1.
- frame_len=10, run drops after 3 strobes -> frame with len=3, tlast on 3rd payload word; next frame seq incremented.
- Write frame_len=2 mid-frame of len 5 -> current frame len 5, following frame len 2.
- Assert rst mid-payload -> o_tvalid=0 immediately, overflow_count=0; after release next frame starts at seq 0.
